io_out_port_buffer: RTL and testbench
=====================================

// Module: io_out_port_buffer
// PURPOSE
//  Device-side end of the CPU I/O port write path; the per-port decoder's registered one-hot `active` vector is its input.
//  - Holds each CPU store to an I/O port in a per-port FIFO.
//  - Presents stored words to external devices with a valid/ready handshake.
//  - Returns a per-port `full` flag, which the CPU uses to annul/retry the store.
//  - One instance covers all output ports of one CPU.
// PARAMETERS
//  WORD_WIDTH  36  data word width, bits
//  PORT_COUNT  4   number of output ports; equals the decoder's port count
//  DEPTH       2   entries per port FIFO; power of 2, >=2
//  CNT_WIDTH   8   overrun counter width (only with IO_OUT_OVERRUN_CNT_EN)
// PORTS
//  clock          in   1                      single clock, rising edge
//  reset          in   1                      synchronous, active-high
//  active         in   PORT_COUNT             registered port-select from port decoder
//  wren           in   1                      CPU store qualifier, same cycle as active
//  write_data     in   WORD_WIDTH             CPU store data, same cycle as active
//  full           out  PORT_COUNT             registered; 1 = port FIFO holds DEPTH words
//  out_data       out  PORT_COUNT*WORD_WIDTH  port i at [i*WORD_WIDTH +: WORD_WIDTH]
//  out_valid      out  PORT_COUNT             port i has a word for its device
//  out_ready      in   PORT_COUNT             device i accepts out_data this cycle
//  overrun_count  out  PORT_COUNT*CNT_WIDTH   only with IO_OUT_OVERRUN_CNT_EN
// BEHAVIOUR
//  Reset: on reset=1 at an edge, all FIFOs go empty with pointers 0. After that edge:
//   full=0, out_valid=0, out_data=0, overrun_count=0. Reset mid-transfer discards stored words.
//  Push: push_i = active[i] & wren & ~full[i]. Pushes write_data at the tail.
//   Evaluated against the pre-edge full value.
//  Pop: pop_i = out_valid[i] & out_ready[i]. Consumes the head word at the edge.
//  Latency: a push at edge N gives out_valid=1 and out_data=word after edge N. There is no same-cycle bypass.
//  Count per port, 0..DEPTH, width clog2(DEPTH)+1:
//   count += push - pop.
//   Pointers wrap modulo DEPTH.
//   full = (count==DEPTH), registered alongside count.
//   out_valid = (count!=0).
//  out_data = mem[rd_ptr] when out_valid=1, else 0. Must be stable while out_valid=1 and out_ready=0.
//  Boundaries:
//   - Full, with push and pop in the same cycle: pop proceeds and push is rejected. The CPU saw full=1.
//   - Empty, with out_ready=1: no pop and no state change.
//   - Push and pop both at count in 1..DEPTH-1: count is unchanged, both pointers advance.
//   - wren=0 or active=0: no push, regardless of write_data.
//   - More than one active bit set: a protocol error. Each selected non-full port still pushes write_data.
//   - out_ready while out_valid=0: ignored.
//  A rejected push (active[i]&wren&full[i]) has no effect on the FIFO.
// CONFIGURATION
//  Macro IO_OUT_OVERRUN_CNT_EN:
//   - Defined: each port has a CNT_WIDTH saturating counter, incremented on every rejected push. It holds at all-ones and clears only on reset. overrun_count is driven.
//   - Undefined: no counter logic and no overrun_count port.
// STRUCTURE
//  Shared package io_pkg:
//   - WORD_WIDTH and PORT_COUNT defaults
//   - clog2-based width function
//   - typedef io_word_t
//  Sub-module io_port_fifo:
//   - One per port, via generate.
//   - Holds the DEPTH-entry memory, rd/wr pointers, count, full, valid and the optional overrun counter.
//   - Top level only slices active, out_data, out_valid, out_ready and overrun_count.
// TESTING
//  1. reset=1 for 2 cycles, then idle -> full=0, out_valid=0, out_data=0 on all ports.
//  2. Port 1 single word:
//     - Stimulus: active=4'b0010, wren=1, write_data=36'hABC at edge N; out_ready=1.
//     - Response: out_valid[1]=1 and out_data[1]=36'hABC after N; popped at N+1, out_valid[1]=0 after.
//  3. Port 0 fill, DEPTH=2:
//     - Stimulus: out_ready=0, write 1 then 2, then attempt 3.
//     - Response: full[0]=1 after the 2nd push; 3rd write dropped; drained order is 1,2.
//     - With the macro defined: overrun_count[0]=1.
//  4. Port 2 full, same cycle:
//     - Stimulus: push and out_ready=1 in one cycle.
//     - Response: one pop, push rejected, count=DEPTH-1, full=0 next cycle.
//  5. Steady streaming, port 3:
//     - Stimulus: push every cycle with out_ready=1 for 100 words.
//     - Response: full never asserts; output matches input order; pointers wrap correctly.
//  6. Reset mid-operation:
//     - Stimulus: reset with 2 words queued on port 0.
//     - Response: out_valid=0 next cycle, queued words never appear.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the CPU I/O output-port write path.
//   WORD_WIDTH_DEF / PORT_COUNT_DEF : default word width and port count
//   io_word_t                       : one data word at the default width
//   cnt_width()                     : width of a 0..depth occupancy counter
package io_pkg;

  localparam int WORD_WIDTH_DEF = 36;
  localparam int PORT_COUNT_DEF = 4;

  typedef logic [WORD_WIDTH_DEF-1:0] io_word_t;

  // Count must reach depth itself, so one bit more than the pointer width.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/io_port_fifo.sv
// One output port's FIFO: stores CPU stores, presents them to a device
// through valid/ready.
// Optional feature macro: IO_OUT_OVERRUN_CNT_EN (saturating count of
// stores rejected because the FIFO was full).
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   active, wren   this port selected by the decoder / store qualifier
//   write_data     store data
//   full           registered, FIFO holds DEPTH words
//   out_data       head word, 0 while empty
//   out_valid      FIFO not empty
//   out_ready      device consumes the head word this cycle
//   overrun_count  rejected-store count (macro only)
module io_port_fifo
  import io_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  active,
  input  logic                  wren,
  input  logic [WORD_WIDTH-1:0] write_data,
  output logic                  full,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef IO_OUT_OVERRUN_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  overrun_count
`endif
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = CW - 1;

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [WORD_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  push, pop;

  // Push is gated by the registered full the CPU saw, so a full FIFO that
  // pops in the same cycle still rejects the store.
  assign push      = active & wren & ~full_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = write_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;  // DEPTH is a power of 2: natural wrap
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset: out_data is forced to 0 whenever empty.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign full     = full_q;
  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;

`ifdef IO_OUT_OVERRUN_CNT_EN
  logic [CNT_WIDTH-1:0] ovr_q, ovr_d;
  logic                 reject;

  assign reject = active & wren & full_q;

  always_comb begin
    ovr_d = ovr_q;
    if (reject && (ovr_q != '1)) begin
      ovr_d = ovr_q + 1'b1;  // saturates at all-ones
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ovr_q <= '0;
    else       ovr_q <= ovr_d;
  end

  assign overrun_count = ovr_q;
`endif

endmodule

// File: rtl/io_out_port_buffer.sv
// Device-side end of the CPU I/O port write path: one FIFO per output port.
// Optional feature macro: IO_OUT_OVERRUN_CNT_EN (adds overrun_count).
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   active         registered one-hot port select from the port decoder
//   wren           store qualifier, same cycle as active
//   write_data     store data
//   full           per-port registered full flag back to the CPU
//   out_data       port i at [i*WORD_WIDTH +: WORD_WIDTH]
//   out_valid      per-port word available
//   out_ready      per-port device accept
//   overrun_count  port i at [i*CNT_WIDTH +: CNT_WIDTH] (macro only)
module io_out_port_buffer
  import io_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int PORT_COUNT = PORT_COUNT_DEF,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [PORT_COUNT-1:0]            active,
  input  logic                             wren,
  input  logic [WORD_WIDTH-1:0]            write_data,
  output logic [PORT_COUNT-1:0]            full,
  output logic [PORT_COUNT*WORD_WIDTH-1:0] out_data,
  output logic [PORT_COUNT-1:0]            out_valid,
  input  logic [PORT_COUNT-1:0]            out_ready
`ifdef IO_OUT_OVERRUN_CNT_EN
  ,
  output logic [PORT_COUNT*CNT_WIDTH-1:0]  overrun_count
`endif
);

  // Multiple active bits are a decoder protocol error; each selected port
  // still independently accepts the word if it has room.
  for (genvar i = 0; i < PORT_COUNT; i++) begin : g_port
    io_port_fifo #(
      .WORD_WIDTH (WORD_WIDTH),
      .DEPTH      (DEPTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .active     (active[i]),
      .wren       (wren),
      .write_data (write_data),
      .full       (full[i]),
      .out_data   (out_data[i*WORD_WIDTH +: WORD_WIDTH]),
      .out_valid  (out_valid[i]),
      .out_ready  (out_ready[i])
`ifdef IO_OUT_OVERRUN_CNT_EN
      ,
      .overrun_count (overrun_count[i*CNT_WIDTH +: CNT_WIDTH])
`endif
    );
  end

endmodule

// File: tb/tb_io_out_port_buffer.sv
module tb_io_out_port_buffer;
  import io_pkg::*;

  logic           clock = 1'b0;
  logic           reset;
  logic [3:0]     active;
  logic           wren;
  io_word_t       write_data;
  logic [3:0]     full;
  logic [143:0]   out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
`ifdef IO_OUT_OVERRUN_CNT_EN
  logic [31:0]    overrun_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  io_out_port_buffer #(.WORD_WIDTH(36), .PORT_COUNT(4), .DEPTH(2), .CNT_WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .active     (active),
    .wren       (wren),
    .write_data (write_data),
    .full       (full),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef IO_OUT_OVERRUN_CNT_EN
    ,
    .overrun_count (overrun_count)
`endif
  );

  typedef struct {
    logic         rst;
    logic [3:0]   act;
    logic         wr;
    logic [35:0]  wd;
    logic [3:0]   rdy;
    logic [3:0]   e_full;
    logic [3:0]   e_vld;
    logic [143:0] e_data;
  } vec_t;

  function automatic logic [143:0] pk(logic [35:0] d3, logic [35:0] d2,
                                      logic [35:0] d1, logic [35:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic vec_t mk(logic rst, logic [3:0] act, logic wr, logic [35:0] wd,
                              logic [3:0] rdy, logic [3:0] ef, logic [3:0] ev,
                              logic [143:0] ed);
    vec_t v;
    v.rst = rst; v.act = act; v.wr = wr; v.wd = wd; v.rdy = rdy;
    v.e_full = ef; v.e_vld = ev; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [143:0] got, input logic [143:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic [3:0] act, input logic wr,
                      input logic [35:0] wd, input logic [3:0] rdy);
    @(negedge clock);
    reset = rst; active = act; wren = wr; write_data = wd; out_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  vec_t tbl[21];

  initial begin
    reset = 1'b1; active = '0; wren = 1'b0; write_data = '0; out_ready = '0;

    tbl[0]  = mk(1, 4'h0, 0, 36'h0,   4'h0, 4'h0, 4'h0, pk(0, 0, 0, 0));
    tbl[1]  = mk(1, 4'h0, 0, 36'h0,   4'h0, 4'h0, 4'h0, pk(0, 0, 0, 0));
    tbl[2]  = mk(0, 4'h0, 0, 36'h0,   4'h0, 4'h0, 4'h0, pk(0, 0, 0, 0));
    // port 1 single word, ready already high while empty
    tbl[3]  = mk(0, 4'h2, 1, 36'hABC, 4'hF, 4'h0, 4'h2, pk(0, 0, 36'hABC, 0));
    tbl[4]  = mk(0, 4'h0, 0, 36'h0,   4'hF, 4'h0, 4'h0, pk(0, 0, 0, 0));
    // port 0 fill, overflow, drain
    tbl[5]  = mk(0, 4'h1, 1, 36'h1,   4'h0, 4'h0, 4'h1, pk(0, 0, 0, 36'h1));
    tbl[6]  = mk(0, 4'h1, 1, 36'h2,   4'h0, 4'h1, 4'h1, pk(0, 0, 0, 36'h1));
    tbl[7]  = mk(0, 4'h1, 1, 36'h3,   4'h0, 4'h1, 4'h1, pk(0, 0, 0, 36'h1));
    tbl[8]  = mk(0, 4'h0, 0, 36'h0,   4'h1, 4'h0, 4'h1, pk(0, 0, 0, 36'h2));
    tbl[9]  = mk(0, 4'h0, 0, 36'h0,   4'h1, 4'h0, 4'h0, pk(0, 0, 0, 0));
    tbl[10] = mk(0, 4'h0, 0, 36'h0,   4'h1, 4'h0, 4'h0, pk(0, 0, 0, 0));
    // port 2 full with push and pop together
    tbl[11] = mk(0, 4'h4, 1, 36'hA1,  4'h0, 4'h0, 4'h4, pk(0, 36'hA1, 0, 0));
    tbl[12] = mk(0, 4'h4, 1, 36'hA2,  4'h0, 4'h4, 4'h4, pk(0, 36'hA1, 0, 0));
    tbl[13] = mk(0, 4'h4, 1, 36'hA3,  4'h4, 4'h0, 4'h4, pk(0, 36'hA2, 0, 0));
    tbl[14] = mk(0, 4'h0, 0, 36'h0,   4'h4, 4'h0, 4'h0, pk(0, 0, 0, 0));
    // two active bits, then wren=0 with data present
    tbl[15] = mk(0, 4'h3, 1, 36'h55,  4'h0, 4'h0, 4'h3, pk(0, 0, 36'h55, 36'h55));
    tbl[16] = mk(0, 4'h3, 0, 36'h66,  4'h0, 4'h0, 4'h3, pk(0, 0, 36'h55, 36'h55));
    tbl[17] = mk(0, 4'h0, 0, 36'h0,   4'h3, 4'h0, 4'h0, pk(0, 0, 0, 0));
    // push+pop at count 1
    tbl[18] = mk(0, 4'h2, 1, 36'h71,  4'h0, 4'h0, 4'h2, pk(0, 0, 36'h71, 0));
    tbl[19] = mk(0, 4'h2, 1, 36'h72,  4'h2, 4'h0, 4'h2, pk(0, 0, 36'h72, 0));
    tbl[20] = mk(0, 4'h0, 0, 36'h0,   4'h2, 4'h0, 4'h0, pk(0, 0, 0, 0));

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rst, tbl[i].act, tbl[i].wr, tbl[i].wd, tbl[i].rdy);
      chk($sformatf("v%0d_full", i),  144'(full),      144'(tbl[i].e_full));
      chk($sformatf("v%0d_valid", i), 144'(out_valid), 144'(tbl[i].e_vld));
      chk($sformatf("v%0d_data", i),  out_data,        tbl[i].e_data);
    end

`ifdef IO_OUT_OVERRUN_CNT_EN
    // one rejected store on port 0 (v7) and one on port 2 (v13)
    chk("overrun_after_table", 144'(overrun_count), 144'({8'd0, 8'd1, 8'd0, 8'd1}));
`endif

    // Streaming on port 3: occupancy stays at 1, pointers wrap every 2 words.
    for (int k = 0; k < 100; k++) begin
      step(0, 4'h8, 1, 36'h300 + 36'(k), 4'h8);
      chk($sformatf("stream%0d_data", k), 144'(out_data[108 +: 36]), 144'(36'h300 + 36'(k)));
      if (k % 10 == 0) begin
        chk($sformatf("stream%0d_valid", k), 144'(out_valid), 144'(4'h8));
        chk($sformatf("stream%0d_full", k),  144'(full),      144'(4'h0));
      end else if (full[3] !== 1'b0) begin
        chk($sformatf("stream%0d_full", k), 144'(full[3]), 144'(1'b0));
      end
    end
    step(0, 4'h0, 0, 36'h0, 4'h8);
    chk("stream_end_valid", 144'(out_valid), 144'(4'h0));

    // Reset with two words queued on port 0.
    step(0, 4'h1, 1, 36'h11, 4'h0);
    step(0, 4'h1, 1, 36'h22, 4'h0);
    chk("mid_full_before", 144'(full), 144'(4'h1));
    step(1, 4'h0, 0, 36'h0, 4'h0);
    chk("mid_rst_valid", 144'(out_valid), 144'(4'h0));
    chk("mid_rst_full",  144'(full),      144'(4'h0));
    chk("mid_rst_data",  out_data,        144'(0));
`ifdef IO_OUT_OVERRUN_CNT_EN
    chk("mid_rst_overrun", 144'(overrun_count), 144'(0));
`endif
    for (int k = 0; k < 3; k++) begin
      step(0, 4'h0, 0, 36'h0, 4'hF);
      chk($sformatf("post_rst%0d_valid", k), 144'(out_valid), 144'(4'h0));
      chk($sformatf("post_rst%0d_data", k),  out_data,        144'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
